// File: rtl/atm_controller_param.sv
// atm_controller_param: ATM session controller (PIN entry with attempt lockout, deposit/withdrawal on an internal balance)
// Ports: clk, rst (async, active-low); inputs tarjeta_recibida, cancelar, tipo_trans, digito_stb/digito, monto_stb/monto;
// registered outputs balance_actualizado, entregar_dinero, pin_incorrecto, advertencia, bloqueo,
// fondos_insuficientes, monto_invalido, tiempo_agotado, sesion_activa, saldo.
module atm_controller_param #(
  parameter int unsigned PIN_DIGITS = 4,
  parameter logic [31:0] PIN_CORRECTO = 32'h0000_4756,
  parameter int unsigned MAX_INTENTOS = 3,
  parameter int unsigned BALANCE_W = 64,
  parameter int unsigned MONTO_W = 32,
  parameter logic [BALANCE_W-1:0] BALANCE_INICIAL = 4500,
  parameter logic [BALANCE_W-1:0] LIMITE_RETIRO = 2000,
  parameter int unsigned TIMEOUT_CICLOS = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tarjeta_recibida,
  input  logic                 cancelar,
  input  logic                 tipo_trans,
  input  logic                 digito_stb,
  input  logic [3:0]           digito,
  input  logic                 monto_stb,
  input  logic [MONTO_W-1:0]   monto,
  output logic                 balance_actualizado,
  output logic                 entregar_dinero,
  output logic                 pin_incorrecto,
  output logic                 advertencia,
  output logic                 bloqueo,
  output logic                 fondos_insuficientes,
  output logic                 monto_invalido,
  output logic                 tiempo_agotado,
  output logic                 sesion_activa,
  output logic [BALANCE_W-1:0] saldo
);
  localparam int unsigned PW = 4 * PIN_DIGITS;
  localparam int unsigned CW = $clog2(PIN_DIGITS + 1);
  localparam int unsigned IW = $clog2(MAX_INTENTOS + 1);
  typedef enum logic [2:0] {ESPERA, PIN, EVAL, TRANS, BLOQUEO} state_t;
  state_t state, state_n;
  logic [IW-1:0] intentos, intentos_n, int_inc;
  logic [CW-1:0] cnt, cnt_n;
  logic [PW-1:0] pin_reg, pin_n;
  logic [31:0] timer, timer_n, tick;
  logic [BALANCE_W-1:0] saldo_n, m;
  logic [BALANCE_W:0] sum;
  logic tout, adv_n, bloq_n, bal_n, ent_n, pinc_n, fon_n, inv_n, tag_n, ses_n;
  always_comb begin
    state_n = state;
    intentos_n = intentos;
    cnt_n = cnt;
    pin_n = pin_reg;
    timer_n = timer;
    saldo_n = saldo;
    adv_n = advertencia;
    bloq_n = bloqueo;
    bal_n = 1'b0;
    ent_n = 1'b0;
    pinc_n = 1'b0;
    fon_n = 1'b0;
    inv_n = 1'b0;
    tag_n = 1'b0;
    int_inc = intentos + 1'b1;
    tick = timer + 32'd1;
    tout = (TIMEOUT_CICLOS != 0) && (tick == TIMEOUT_CICLOS);
    m = BALANCE_W'(monto);
    sum = {1'b0, saldo} + {1'b0, m};
    case (state)
      ESPERA: if (tarjeta_recibida) begin
        state_n = PIN;
        cnt_n = '0;
        pin_n = '0;
        timer_n = '0;
      end
      PIN: if (cancelar) begin
        state_n = ESPERA;
        adv_n = 1'b0;
      end else if (digito_stb && digito <= 4'd9) begin
        pin_n = PW'({pin_reg, digito});
        cnt_n = cnt + 1'b1;
        timer_n = '0;
        if (cnt == CW'(PIN_DIGITS - 1)) state_n = EVAL;
      end else if (tout) begin
        state_n = ESPERA;
        tag_n = 1'b1;
        adv_n = 1'b0;
      end else timer_n = tick;
      EVAL: if (cancelar) begin
        state_n = ESPERA;
        adv_n = 1'b0;
      end else if (pin_reg == PIN_CORRECTO[PW-1:0]) begin
        state_n = TRANS;
        intentos_n = '0;
        adv_n = 1'b0;
        timer_n = '0;
      end else begin
        intentos_n = int_inc;
        pinc_n = 1'b1;
        cnt_n = '0;
        timer_n = '0;
        state_n = (int_inc == IW'(MAX_INTENTOS)) ? BLOQUEO : PIN;
        bloq_n = (int_inc == IW'(MAX_INTENTOS));
        if (int_inc == IW'(MAX_INTENTOS - 1)) adv_n = 1'b1;
      end
      TRANS: if (cancelar) begin
        state_n = ESPERA;
        adv_n = 1'b0;
      end else if (monto_stb) begin
        state_n = ESPERA;
        if (m == '0) inv_n = 1'b1;
        else if (!tipo_trans) begin
          inv_n = sum[BALANCE_W];
          bal_n = !sum[BALANCE_W];
          saldo_n = sum[BALANCE_W] ? saldo : sum[BALANCE_W-1:0];
        end else if (m > LIMITE_RETIRO) inv_n = 1'b1;
        else if (m > saldo) fon_n = 1'b1;
        else begin
          saldo_n = saldo - m;
          ent_n = 1'b1;
          bal_n = 1'b1;
        end
      end else if (tout) begin
        state_n = ESPERA;
        tag_n = 1'b1;
        adv_n = 1'b0;
      end else timer_n = tick;
      default: ;
    endcase
    ses_n = (state_n == PIN) || (state_n == EVAL) || (state_n == TRANS);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ESPERA;
      intentos <= '0;
      cnt <= '0;
      pin_reg <= '0;
      timer <= '0;
      saldo <= BALANCE_INICIAL;
      advertencia <= 1'b0;
      bloqueo <= 1'b0;
      balance_actualizado <= 1'b0;
      entregar_dinero <= 1'b0;
      pin_incorrecto <= 1'b0;
      fondos_insuficientes <= 1'b0;
      monto_invalido <= 1'b0;
      tiempo_agotado <= 1'b0;
      sesion_activa <= 1'b0;
    end else begin
      state <= state_n;
      intentos <= intentos_n;
      cnt <= cnt_n;
      pin_reg <= pin_n;
      timer <= timer_n;
      saldo <= saldo_n;
      advertencia <= adv_n;
      bloqueo <= bloq_n;
      balance_actualizado <= bal_n;
      entregar_dinero <= ent_n;
      pin_incorrecto <= pinc_n;
      fondos_insuficientes <= fon_n;
      monto_invalido <= inv_n;
      tiempo_agotado <= tag_n;
      sesion_activa <= ses_n;
    end
  end
endmodule

// File: tb/tb_atm_controller_param.sv
// tb_atm_controller_param: directed checks of the ATM controller in three parameterisations
module tb_atm_controller_param;
  logic clk = 1'b0, rst = 1'b0;
  logic tarjeta = 1'b0, cancelar = 1'b0, tipo = 1'b0, digito_stb = 1'b0, monto_stb = 1'b0;
  logic [3:0] digito = '0;
  logic [31:0] monto = '0;
  int checks = 0, failures = 0;
  logic bal0, ent0, pinc0, adv0, bloq0, fon0, inv0, tag0, ses0;
  logic [63:0] saldo0;
  logic bal1, ent1, pinc1, adv1, bloq1, fon1, inv1, tag1, ses1;
  logic [63:0] saldo1;
  logic bal2, ent2, pinc2, adv2, bloq2, fon2, inv2, tag2, ses2;
  logic [15:0] saldo2;
  always #5 clk = ~clk;
  atm_controller_param dut0 (
    .clk(clk), .rst(rst), .tarjeta_recibida(tarjeta), .cancelar(cancelar), .tipo_trans(tipo),
    .digito_stb(digito_stb), .digito(digito), .monto_stb(monto_stb), .monto(monto),
    .balance_actualizado(bal0), .entregar_dinero(ent0), .pin_incorrecto(pinc0), .advertencia(adv0),
    .bloqueo(bloq0), .fondos_insuficientes(fon0), .monto_invalido(inv0), .tiempo_agotado(tag0),
    .sesion_activa(ses0), .saldo(saldo0));
  atm_controller_param #(.TIMEOUT_CICLOS(10)) dut1 (
    .clk(clk), .rst(rst), .tarjeta_recibida(tarjeta), .cancelar(cancelar), .tipo_trans(tipo),
    .digito_stb(digito_stb), .digito(digito), .monto_stb(monto_stb), .monto(monto),
    .balance_actualizado(bal1), .entregar_dinero(ent1), .pin_incorrecto(pinc1), .advertencia(adv1),
    .bloqueo(bloq1), .fondos_insuficientes(fon1), .monto_invalido(inv1), .tiempo_agotado(tag1),
    .sesion_activa(ses1), .saldo(saldo1));
  atm_controller_param #(.BALANCE_W(16), .MONTO_W(16), .BALANCE_INICIAL(16'd65000)) dut2 (
    .clk(clk), .rst(rst), .tarjeta_recibida(tarjeta), .cancelar(cancelar), .tipo_trans(tipo),
    .digito_stb(digito_stb), .digito(digito), .monto_stb(monto_stb), .monto(monto[15:0]),
    .balance_actualizado(bal2), .entregar_dinero(ent2), .pin_incorrecto(pinc2), .advertencia(adv2),
    .bloqueo(bloq2), .fondos_insuficientes(fon2), .monto_invalido(inv2), .tiempo_agotado(tag2),
    .sesion_activa(ses2), .saldo(saldo2));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
  endtask
  task automatic card();
    tarjeta = 1'b1;
    step();
    tarjeta = 1'b0;
  endtask
  task automatic key(input logic [3:0] d);
    digito_stb = 1'b1;
    digito = d;
    step();
    digito_stb = 1'b0;
  endtask
  task automatic enter_pin(input logic [15:0] p);
    for (int i = 3; i >= 0; i--) key(p[4*i +: 4]);
    step();
  endtask
  task automatic amount(input logic t, input logic [31:0] v);
    monto_stb = 1'b1;
    tipo = t;
    monto = v;
    step();
    monto_stb = 1'b0;
  endtask
  task automatic cancel();
    cancelar = 1'b1;
    step();
    cancelar = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b0;
    step();
    checks++;
    if ({bal0, ent0, pinc0, adv0, bloq0, fon0, inv0, tag0, ses0} !== 9'b0 || saldo0 !== 64'd4500) begin
      failures++;
      $display("FAIL reset: flags=%b saldo=%0d, required flags=0 saldo=4500",
               {bal0, ent0, pinc0, adv0, bloq0, fon0, inv0, tag0, ses0}, saldo0);
    end
    rst = 1'b1;
    step();
  endtask
  task automatic test_deposit();
    card();
    checks++;
    if (ses0 !== 1'b1) begin failures++; $display("FAIL dep_session: got %b want 1", ses0); end
    enter_pin(16'h4756);
    checks++;
    if (pinc0 !== 1'b0 || ses0 !== 1'b1) begin failures++; $display("FAIL dep_pin_ok: pinc=%b ses=%b want 0 1", pinc0, ses0); end
    amount(1'b0, 32'd500);
    checks++;
    if (bal0 !== 1'b1 || saldo0 !== 64'd5000 || ses0 !== 1'b0) begin
      failures++;
      $display("FAIL dep_result: bal=%b saldo=%0d ses=%b want 1 5000 0", bal0, saldo0, ses0);
    end
    step();
    checks++;
    if (bal0 !== 1'b0) begin failures++; $display("FAIL dep_pulse_width: bal=%b want 0", bal0); end
  endtask
  task automatic test_withdraw();
    do_reset();
    card(); enter_pin(16'h4756); amount(1'b1, 32'd1500);
    checks++;
    if (ent0 !== 1'b1 || bal0 !== 1'b1 || saldo0 !== 64'd3000) begin
      failures++;
      $display("FAIL wd_ok: ent=%b bal=%b saldo=%0d want 1 1 3000", ent0, bal0, saldo0);
    end
    card(); enter_pin(16'h4756); amount(1'b1, 32'd2500);
    checks++;
    if (inv0 !== 1'b1 || ent0 !== 1'b0 || saldo0 !== 64'd3000) begin
      failures++;
      $display("FAIL wd_limit: inv=%b ent=%b saldo=%0d want 1 0 3000", inv0, ent0, saldo0);
    end
    card(); enter_pin(16'h4756); amount(1'b1, 32'd2000);
    checks++;
    if (ent0 !== 1'b1 || saldo0 !== 64'd1000) begin
      failures++;
      $display("FAIL wd_at_limit: ent=%b saldo=%0d want 1 1000", ent0, saldo0);
    end
    card(); enter_pin(16'h4756); amount(1'b1, 32'd1600);
    checks++;
    if (fon0 !== 1'b1 || inv0 !== 1'b0 || bal0 !== 1'b0 || saldo0 !== 64'd1000) begin
      failures++;
      $display("FAIL wd_funds: fon=%b inv=%b bal=%b saldo=%0d want 1 0 0 1000", fon0, inv0, bal0, saldo0);
    end
  endtask
  task automatic test_lockout();
    do_reset();
    card(); enter_pin(16'h1111);
    checks++;
    if (pinc0 !== 1'b1 || adv0 !== 1'b0 || ses0 !== 1'b1) begin
      failures++;
      $display("FAIL wrong1: pinc=%b adv=%b ses=%b want 1 0 1", pinc0, adv0, ses0);
    end
    step();
    checks++;
    if (pinc0 !== 1'b0) begin failures++; $display("FAIL wrong1_pulse: pinc=%b want 0", pinc0); end
    enter_pin(16'h1111);
    checks++;
    if (pinc0 !== 1'b1 || adv0 !== 1'b1 || bloq0 !== 1'b0) begin
      failures++;
      $display("FAIL wrong2: pinc=%b adv=%b bloq=%b want 1 1 0", pinc0, adv0, bloq0);
    end
    enter_pin(16'h1111);
    checks++;
    if (pinc0 !== 1'b1 || bloq0 !== 1'b1 || ses0 !== 1'b0) begin
      failures++;
      $display("FAIL wrong3: pinc=%b bloq=%b ses=%b want 1 1 0", pinc0, bloq0, ses0);
    end
    card(); enter_pin(16'h4756);
    checks++;
    if (bloq0 !== 1'b1 || ses0 !== 1'b0 || pinc0 !== 1'b0) begin
      failures++;
      $display("FAIL locked_ignore: bloq=%b ses=%b pinc=%b want 1 0 0", bloq0, ses0, pinc0);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bloq0 !== 1'b0 || adv0 !== 1'b0 || saldo0 !== 64'd4500) begin
      failures++;
      $display("FAIL async_reset: bloq=%b adv=%b saldo=%0d want 0 0 4500", bloq0, adv0, saldo0);
    end
    step();
    rst = 1'b1;
    step();
  endtask
  task automatic test_digits_cancel();
    do_reset();
    card(); key(4'h4); key(4'hA); key(4'h7); key(4'h5); key(4'h6); step();
    checks++;
    if (pinc0 !== 1'b0 || ses0 !== 1'b1) begin
      failures++;
      $display("FAIL bad_digit_ignored: pinc=%b ses=%b want 0 1", pinc0, ses0);
    end
    cancel();
    checks++;
    if (ses0 !== 1'b0 || {bal0, ent0, inv0, fon0, tag0} !== 5'b0) begin
      failures++;
      $display("FAIL cancel_trans: ses=%b pulses=%b want 0 0", ses0, {bal0, ent0, inv0, fon0, tag0});
    end
    card(); key(4'h4); key(4'h7);
    cancelar = 1'b1; digito_stb = 1'b1; digito = 4'h5;
    step();
    cancelar = 1'b0; digito_stb = 1'b0;
    checks++;
    if (ses0 !== 1'b0 || pinc0 !== 1'b0) begin
      failures++;
      $display("FAIL cancel_with_digit: ses=%b pinc=%b want 0 0", ses0, pinc0);
    end
    card(); enter_pin(16'h1111); cancel();
    card(); enter_pin(16'h1111);
    checks++;
    if (pinc0 !== 1'b1 || adv0 !== 1'b1 || bloq0 !== 1'b0) begin
      failures++;
      $display("FAIL attempts_persist: pinc=%b adv=%b bloq=%b want 1 1 0", pinc0, adv0, bloq0);
    end
    cancel();
    checks++;
    if (adv0 !== 1'b0) begin failures++; $display("FAIL cancel_clears_adv: adv=%b want 0", adv0); end
    card(); enter_pin(16'h4756); cancel();
    card(); enter_pin(16'h1111);
    checks++;
    if (pinc0 !== 1'b1 || adv0 !== 1'b0) begin
      failures++;
      $display("FAIL success_clears_attempts: pinc=%b adv=%b want 1 0", pinc0, adv0);
    end
  endtask
  task automatic test_timeout();
    int seen;
    do_reset();
    card();
    repeat (9) step();
    checks++;
    if (tag1 !== 1'b0 || ses1 !== 1'b1) begin
      failures++;
      $display("FAIL timeout_early: tag=%b ses=%b want 0 1", tag1, ses1);
    end
    step();
    checks++;
    if (tag1 !== 1'b1 || ses1 !== 1'b0) begin
      failures++;
      $display("FAIL timeout_fire: tag=%b ses=%b want 1 0", tag1, ses1);
    end
    step();
    checks++;
    if (tag1 !== 1'b0) begin failures++; $display("FAIL timeout_pulse: tag=%b want 0", tag1); end
    card();
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 8; j++) begin
        step();
        seen += int'(tag1);
      end
      key(4'h1);
      seen += int'(tag1);
    end
    checks++;
    if (seen != 0 || ses1 !== 1'b1) begin
      failures++;
      $display("FAIL timeout_kept_alive: pulses=%0d ses=%b want 0 1", seen, ses1);
    end
  endtask
  task automatic test_overflow();
    do_reset();
    checks++;
    if (saldo2 !== 16'd65000) begin failures++; $display("FAIL ovf_init: saldo=%0d want 65000", saldo2); end
    card(); enter_pin(16'h4756); amount(1'b0, 32'd1000);
    checks++;
    if (inv2 !== 1'b1 || bal2 !== 1'b0 || saldo2 !== 16'd65000) begin
      failures++;
      $display("FAIL ovf_deposit: inv=%b bal=%b saldo=%0d want 1 0 65000", inv2, bal2, saldo2);
    end
    card(); enter_pin(16'h4756); amount(1'b0, 32'd0);
    checks++;
    if (inv2 !== 1'b1 || saldo2 !== 16'd65000) begin
      failures++;
      $display("FAIL zero_deposit: inv=%b saldo=%0d want 1 65000", inv2, saldo2);
    end
    card(); enter_pin(16'h4756); amount(1'b0, 32'd535);
    checks++;
    if (bal2 !== 1'b1 || inv2 !== 1'b0 || saldo2 !== 16'd65535) begin
      failures++;
      $display("FAIL max_deposit: bal=%b inv=%b saldo=%0d want 1 0 65535", bal2, inv2, saldo2);
    end
  endtask
  initial begin
    test_reset();
    test_deposit();
    test_withdraw();
    test_lockout();
    test_digits_cancel();
    test_timeout();
    test_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
